// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Game-flow controller that sits upstream of the ball block.
//            Debounces the start/pause button, runs the IDLE/SERVE/PLAY/
//            POINT/PAUSE/OVER sequence, ramps the ball speed and latches
//            the winner.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter int          DEBOUNCE_CYC = 500000,
  parameter int          SERVE_FRAMES = 120,
  parameter int          PAUSE_FRAMES = 60,
  parameter int          RAMP_FRAMES  = 300,
  parameter logic [21:0] PRESC_BASE   = 22'd250000,
  parameter logic [21:0] PRESC_MIN    = 22'd100000,
  parameter logic [21:0] RAMP_STEP    = 22'd10000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        btn,
  input  logic        frame_tick,
  input  logic [1:0]  p1_score,
  input  logic [1:0]  p2_score,
  input  logic        gamestop,
  output logic        start,
  output logic [21:0] prescaler,
  output logic [1:0]  winner,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

  localparam int FMAX0 = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int FMAX  = (FMAX0 > RAMP_FRAMES) ? FMAX0 : RAMP_FRAMES;
  localparam int FW    = $clog2(FMAX + 1);
  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] PAUSE_LAST = FW'(PAUSE_FRAMES - 1);
  localparam logic [FW-1:0] RAMP_LAST  = FW'(RAMP_FRAMES - 1);

  // Smallest prescaler that can still take a full step without dropping below the floor
  localparam logic [22:0] STEP_FLOOR = {1'b0, PRESC_MIN} + {1'b0, RAMP_STEP};

  logic          sync1, sync2;
  logic          btn_lvl;
  logic [DW-1:0] deb_cnt;
  logic          press;

  logic [1:0]    p1_prev, p2_prev;
  logic          gs_prev;
  logic          score_chg, gs_rise;

  logic [2:0]    state, nstate;
  logic [FW-1:0] fcnt;
  logic          ramp;
  logic [21:0]   presc_dec;

  // Two-stage synchronizer for the asynchronous button
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: count while the synced level disagrees with the accepted one; any bounce back restarts
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_cnt <= '0;
      btn_lvl <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= (sync2 != btn_lvl) && (deb_cnt == DEB_LAST) && sync2;
      if (sync2 == btn_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        btn_lvl <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Previous copies of the ball block outputs for edge/change detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p1_prev <= 2'd0;
      p2_prev <= 2'd0;
      gs_prev <= 1'b0;
    end else begin
      p1_prev <= p1_score;
      p2_prev <= p2_score;
      gs_prev <= gamestop;
    end
  end

  assign score_chg = (p1_score != p1_prev) || (p2_score != p2_prev);
  assign gs_rise   = gamestop && !gs_prev;
  assign presc_dec = ({1'b0, prescaler} >= STEP_FLOOR) ? (prescaler - RAMP_STEP) : PRESC_MIN;

  // Next-state and ramp decision; score/game-over events only matter in PLAY
  always_comb begin
    nstate = state;
    ramp   = 1'b0;
    case (state)
      S_IDLE:  if (press) nstate = S_SERVE;
      S_SERVE: if (frame_tick && fcnt == SERVE_LAST) nstate = S_PLAY;
      S_PLAY: begin
        if (gs_rise)                                nstate = S_OVER;
        else if (score_chg)                         nstate = S_POINT;
        else if (press)                             nstate = S_PAUSE;
        else if (frame_tick && fcnt == RAMP_LAST)   ramp   = 1'b1;
      end
      S_POINT: if (frame_tick && fcnt == PAUSE_LAST) nstate = S_PLAY;
      S_PAUSE: if (press) nstate = S_PLAY;
      S_OVER:  if (press) nstate = S_SERVE;
      default: nstate = S_IDLE;
    endcase
  end

  // Frame counter: cleared on every state entry and at each ramp step, else counts ticks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fcnt <= '0;
    end else if ((nstate != state) || ramp) begin
      fcnt <= '0;
    end else if (frame_tick) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // State register and registered outputs, all decoded from the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      start     <= 1'b0;
      prescaler <= PRESC_BASE;
      winner    <= 2'b00;
    end else begin
      state <= nstate;
      start <= (nstate == S_PLAY);
      if ((nstate == S_SERVE) || (nstate == S_POINT))
        prescaler <= PRESC_BASE;
      else if (ramp)
        prescaler <= presc_dec;
      if (nstate == S_SERVE)
        winner <= 2'b00;
      else if ((state == S_PLAY) && gs_rise)
        winner <= {(p2_prev == 2'd2), (p1_prev == 2'd2)};
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire
